reg_bridge: RTL and testbench
=============================

REG_BRIDGE -- requirements
Module: reg_bridge

Interface
REQ-001 Parameter REGS, default 3, number of core registers decoded.
REQ-002 Parameter ADDR_W, default 4, width of word address; SHALL satisfy 2**ADDR_W >= REGS.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  ADDR_W  bus word address.
REQ-006 write  input  1  bus write request.
REQ-007 writedata  input  32  bus write data.
REQ-008 read  input  1  bus read request.
REQ-009 waitrequest  output  1  high = request not accepted this cycle.
REQ-010 readdata  output  32  read data, valid only with readdatavalid.
REQ-011 readdatavalid  output  1  one-cycle read completion pulse.
REQ-012 response  output  2  00 OKAY, 10 SLVERR; valid with readdatavalid.
REQ-013 core_data_in  output  32  write data to core.
REQ-014 core_data_out  input  REGS x 32  per-register read data from core.
REQ-015 core_write_en  output  REGS  one-hot write strobes.
REQ-016 core_read_en  output  REGS  one-hot read strobes.
REQ-017 core_irq  input  1  core interrupt request.
REQ-018 irq  output  1  registered interrupt to system.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; waitrequest SHALL be 0 only in IDLE.
REQ-020 Request accepted in cycle N when in IDLE and (read or write) is high; address, writedata, op captured.
REQ-021 Accepted valid write: ACCESS in N+1 with core_write_en[address]=1 for exactly one cycle and core_data_in=captured writedata; IDLE in N+2.
REQ-022 Accepted valid read: ACCESS in N+1 with core_read_en[address]=1 for one cycle; core_data_out[address] sampled at end of N+1; RESP in N+2 with readdatavalid=1, readdata=sample, response=00; IDLE in N+3.
REQ-023 Address >= REGS: no strobe asserted; a read SHALL complete on the same timing as REQ-022 with readdata=0, response=10; a write SHALL be dropped, IDLE in N+2.
REQ-024 read and write both high at acceptance: treated as read with response=10, readdata=0, no strobes.
REQ-025 Requests presented while waitrequest=1 SHALL be ignored; master must hold them.
REQ-026 At most one bit of core_write_en/core_read_en high in any cycle; never both vectors nonzero.
REQ-027 core_data_in SHALL be 0 outside ACCESS-write cycles; readdata SHALL be 0 outside RESP.
REQ-028 irq SHALL equal core_irq delayed one cycle.
REQ-029 Throughput: one write per 2 cycles, one read per 3 cycles at most.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE and all outputs 0 (waitrequest, readdata, readdatavalid, response, core_data_in, strobes, irq) without clock.
REQ-031 Reset during ACCESS or RESP SHALL abort the transaction; no strobe or readdatavalid after reset_n deasserts until a new request.
REQ-032 First request accepted on the first rising edge after reset_n release.

Structure
REQ-033 Shared package reg_bridge_pkg SHALL hold the state enum, response codes RESP_OKAY/RESP_SLVERR, and the bus data width 32.
REQ-034 One sub-module reg_decoder SHALL convert captured address plus enable into a REGS-wide one-hot vector with an out-of-range flag.

Verification
REQ-035 Write 0x0000_1234 to addr 0 at cycle N -> core_write_en=001 and core_data_in=0x0000_1234 at N+1 only; waitrequest low again N+2.
REQ-036 Read addr 1 with core_data_out[1]=0x5 -> core_read_en=010 at N+1; readdatavalid=1, readdata=0x5, response=00 at N+2.
REQ-037 Read addr 7 -> no strobes; readdatavalid at N+2 with readdata=0, response=10; write addr 3 -> no strobes, IDLE at N+2.
REQ-038 read=write=1 addr 0 -> no strobes, response=10 at N+2; request held high through waitrequest -> exactly one transaction accepted per IDLE cycle.
REQ-039 reset_n pulsed low during ACCESS of a read -> all outputs 0 asynchronously, no readdatavalid afterwards; next read completes normally.
REQ-040 core_irq 0->1 at cycle M -> irq 1 at M+1; back-to-back writes to addr 0,1,2 -> strobes 001,010,100 at 2-cycle spacing.

Source files
------------

// File: rtl/reg_bridge_pkg.sv
// Shared types and constants for the register bridge: FSM states,
// bus response codes and the bus data width.
package reg_bridge_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/reg_bridge_if.sv
// Memory-mapped bus between a system master and the register bridge.
interface reg_bridge_if #(
  parameter int unsigned ADDR_W = 4
);
  import reg_bridge_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic [1:0]        response;

  modport master (
    output address, write, writedata, read,
    input  waitrequest, readdata, readdatavalid, response
  );

  modport slave (
    input  address, write, writedata, read,
    output waitrequest, readdata, readdatavalid, response
  );

endinterface

// File: rtl/reg_bridge_decoder.sv
// Turns a captured word address plus enable into a one-hot register
// select, flagging addresses beyond the decoded register range.
module reg_decoder #(
  parameter int unsigned REGS   = 3,
  parameter int unsigned ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [REGS-1:0]   onehot,
  output logic              out_of_range
);

  always_comb begin
    out_of_range = (32'(addr) >= REGS);
    onehot       = '0;
    for (int unsigned i = 0; i < REGS; i++) begin
      onehot[i] = en && !out_of_range && (32'(addr) == i);
    end
  end

endmodule

// File: rtl/reg_bridge.sv
// Bus-to-core register bridge: accepts one request in IDLE, strobes the
// addressed core register in ACCESS, and returns read data in RESP.
module reg_bridge
  import reg_bridge_pkg::*;
#(
  parameter int unsigned REGS   = 3,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  reg_bridge_if.slave                bus,
  output logic [DATA_W-1:0]          core_data_in,
  input  logic [REGS-1:0][DATA_W-1:0] core_data_out,
  output logic [REGS-1:0]            core_write_en,
  output logic [REGS-1:0]            core_read_en,
  input  logic                       core_irq,
  output logic                       irq
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              bad_q;

  logic              dec_en;
  logic [REGS-1:0]   sel;
  logic              oor;
  logic [DATA_W-1:0] rd_mux;

  // A simultaneous read+write is served as an erroring read, so it never selects a register.
  assign dec_en = (state == ACCESS) && !bad_q;

  reg_decoder #(
    .REGS   (REGS),
    .ADDR_W (ADDR_W)
  ) u_decoder (
    .addr         (addr_q),
    .en           (dec_en),
    .onehot       (sel),
    .out_of_range (oor)
  );

  always_comb begin
    bus.waitrequest = (state != IDLE);
    core_write_en   = rd_q ? '0 : sel;
    core_read_en    = rd_q ? sel : '0;
    core_data_in    = (state == ACCESS && !rd_q && !oor) ? wdata_q : '0;
    rd_mux          = '0;
    for (int unsigned i = 0; i < REGS; i++) begin
      if (sel[i]) rd_mux = rd_mux | core_data_out[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      addr_q            <= '0;
      wdata_q           <= '0;
      rd_q              <= 1'b0;
      bad_q             <= 1'b0;
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
      bus.response      <= RESP_OKAY;
      irq               <= 1'b0;
    end else begin
      irq               <= core_irq;
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
      bus.response      <= RESP_OKAY;
      case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            addr_q  <= bus.address;
            wdata_q <= bus.writedata;
            rd_q    <= bus.read;
            bad_q   <= bus.read && bus.write;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (rd_q) begin
            bus.readdatavalid <= 1'b1;
            bus.readdata      <= rd_mux;
            bus.response      <= (bad_q || oor) ? RESP_SLVERR : RESP_OKAY;
            state             <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bridge.sv
// Randomized scoreboard bench for reg_bridge: the driver pushes expected
// strobes/responses, a monitor pops and compares them cycle by cycle.
module tb_reg_bridge;
  import reg_bridge_pkg::*;

  localparam int unsigned REGS   = 3;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [DATA_W-1:0]           core_data_in;
  logic [REGS-1:0][DATA_W-1:0] core_data_out;
  logic [REGS-1:0]             core_write_en;
  logic [REGS-1:0]             core_read_en;
  logic                        core_irq;
  logic                        irq;

  reg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  reg_bridge #(.REGS(REGS), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .core_data_in  (core_data_in),
    .core_data_out (core_data_out),
    .core_write_en (core_write_en),
    .core_read_en  (core_read_en),
    .core_irq      (core_irq),
    .irq           (irq)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int              cyc;
    logic [REGS-1:0] en;
    logic [31:0]     data;
  } stb_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    bit                err;
  } rsp_t;

  stb_t wq[$];
  stb_t rq[$];
  rsp_t pq[$];

  int free_at  = 0;
  int irq_from = 32'h7fff_ffff;
  bit mon_on   = 1'b0;

  logic [REGS-1:0][DATA_W-1:0] dhist[int];
  bit                          ihist[int];
  bit                          skip_din[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_waitreq"}, 32'(bus.waitrequest), 0);
    chk({tag, "_rdata"},   bus.readdata, 0);
    chk({tag, "_rdvalid"}, 32'(bus.readdatavalid), 0);
    chk({tag, "_resp"},    32'(bus.response), 0);
    chk({tag, "_din"},     core_data_in, 0);
    chk({tag, "_wen"},     32'(core_write_en), 0);
    chk({tag, "_ren"},     32'(core_read_en), 0);
    chk({tag, "_irq"},     32'(irq), 0);
  endtask

  // Core side: fresh random register contents and irq every cycle, with history.
  initial begin
    for (int i = 0; i < REGS; i++) core_data_out[i] = $urandom;
    core_irq = 1'b0;
    dhist[0] = core_data_out;
    ihist[0] = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < REGS; i++) core_data_out[i] = $urandom;
      core_irq   = 1'($urandom_range(0, 1));
      dhist[cyc] = core_data_out;
      ihist[cyc] = core_irq;
    end
  end

  // Monitor
  initial begin
    stb_t e;
    rsp_t p;
    logic [31:0] exp_data;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && mon_on) begin
        chk("waitreq", 32'(bus.waitrequest), 32'(cyc < free_at));
        if (cyc >= irq_from) chk("irq", 32'(irq), 32'(ihist[cyc-1]));

        if (wq.size() > 0 && wq[0].cyc == cyc) begin
          e = wq.pop_front();
          chk("wr_en", 32'(core_write_en), 32'(e.en));
          chk("wr_data", core_data_in, e.data);
        end else begin
          chk("wr_en_idle", 32'(core_write_en), 0);
          if (!skip_din.exists(cyc)) chk("din_idle", core_data_in, 0);
        end

        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          e = rq.pop_front();
          chk("rd_en", 32'(core_read_en), 32'(e.en));
        end else begin
          chk("rd_en_idle", 32'(core_read_en), 0);
        end

        if (pq.size() > 0 && pq[0].cyc == cyc) begin
          p = pq.pop_front();
          if (p.err) exp_data = '0;
          else       exp_data = dhist[cyc-1][p.addr];
          chk("rdvalid", 32'(bus.readdatavalid), 1);
          chk("rdata", bus.readdata, exp_data);
          chk("resp", 32'(bus.response), p.err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
        end else begin
          chk("rdvalid_idle", 32'(bus.readdatavalid), 0);
          chk("rdata_idle", bus.readdata, 0);
        end
      end
    end
  end

  // Presents a request (called at a negedge), holds it until the reference
  // model says the bridge is free, records expectations, then idles 'gap' cycles.
  task automatic issue(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, input int gap);
    int n;
    bit err;
    logic [REGS-1:0] oh;
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = d;
    while (cyc < free_at) @(negedge clk);
    n  = cyc;
    oh = '0;
    if (32'(a) < REGS) oh[a] = 1'b1;
    if (rd) begin
      err = wr || (32'(a) >= REGS);
      if (!err) rq.push_back('{n + 1, oh, 32'h0});
      pq.push_back('{n + 2, a, err});
      free_at = n + 3;
    end else begin
      if (32'(a) < REGS) wq.push_back('{n + 1, oh, d});
      else               skip_din[n + 1] = 1'b1;
      free_at = n + 2;
    end
    @(negedge clk);
    if (gap > 0) begin
      bus.read  = 1'b0;
      bus.write = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    int unsigned s;
    logic [ADDR_W-1:0] a;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_all_zero("reset");

    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    free_at  = cyc;
    irq_from = cyc + 1;
    mon_on   = 1'b1;

    issue(1'b0, 1'b1, 4'd0, 32'h0000_1234, 1);
    issue(1'b1, 1'b0, 4'd1, 32'h0, 1);
    issue(1'b1, 1'b0, 4'd7, 32'h0, 1);
    issue(1'b0, 1'b1, 4'd3, 32'hdead_beef, 1);
    issue(1'b1, 1'b1, 4'd0, 32'h0, 0);
    issue(1'b0, 1'b1, 4'd0, 32'haaaa_0000, 0);
    issue(1'b0, 1'b1, 4'd1, 32'h0000_bbbb, 0);
    issue(1'b0, 1'b1, 4'd2, 32'hc0c0_c0c0, 2);

    // Abort a read while it is in ACCESS.
    issue(1'b1, 1'b0, 4'd1, 32'h0, 0);
    bus.read = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_all_zero("abort");
    wq.delete();
    rq.delete();
    pq.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    free_at  = cyc;
    irq_from = cyc + 1;
    issue(1'b1, 1'b0, 4'd2, 32'h0, 2);

    for (int k = 0; k < 300; k++) begin
      s = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(0, 15));
      else                           a = ADDR_W'($urandom_range(0, REGS - 1));
      issue((s <= 3), (s == 0) || (s >= 4), a, $urandom, $urandom_range(0, 2));
    end

    bus.read  = 1'b0;
    bus.write = 1'b0;
    repeat (6) @(negedge clk);
    chk("wq_drained", 32'(wq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);
    chk("pq_drained", 32'(pq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
